// File: rtl/vjtag_uart_fifo.sv
// Byte buffering between the VirtualJTAG UART (m_clock side) and user logic:
// an RX FIFO for host bytes and a TX FIFO drained by the UART's send_ready requests.
module vjtag_uart_fifo #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [7:0]  IDLE_BYTE  = 8'h00
) (
    input  logic                  m_clock,
    input  logic                  p_reset,
    input  logic                  recv,
    input  logic [7:0]            recv_data,
    input  logic                  send_ready,
    output logic                  send,
    output logic [7:0]            send_data,
    output logic                  rx_valid,
    output logic [7:0]            rx_data,
    input  logic                  rx_ready,
    input  logic                  tx_valid,
    input  logic [7:0]            tx_data,
    output logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic                  rx_overflow,
    output logic                  tx_underrun,
    input  logic                  clr_flags
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } send_state_t;

    // ---------------- RX FIFO ----------------
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rx_rd_ptr_reg;
    logic [DEPTH_LOG2:0]   rx_count_reg;
    logic                  rx_overflow_reg;
    logic                  rx_full;
    logic                  rx_pop;
    logic                  rx_push;
    logic                  rx_drop;

    assign rx_full  = (rx_count_reg == FULL_COUNT);
    assign rx_valid = (rx_count_reg != '0);
    assign rx_pop   = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot the push writes into, even when full.
    assign rx_push  = recv & (~rx_full | rx_pop);
    assign rx_drop  = recv & ~rx_push;
    assign rx_data  = rx_mem[rx_rd_ptr_reg];

    always_ff @(posedge m_clock) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr_reg] <= recv_data;
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            rx_wr_ptr_reg   <= '0;
            rx_rd_ptr_reg   <= '0;
            rx_count_reg    <= '0;
            rx_overflow_reg <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
            end
            if (rx_pop) begin
                rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count_reg <= rx_count_reg + COUNT_ONE;
                2'b01:   rx_count_reg <= rx_count_reg - COUNT_ONE;
                default: rx_count_reg <= rx_count_reg;
            endcase
            if (rx_drop) begin
                rx_overflow_reg <= 1'b1;
            end else if (clr_flags) begin
                rx_overflow_reg <= 1'b0;
            end
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] tx_rd_ptr_reg;
    logic [DEPTH_LOG2:0]   tx_count_reg;
    logic                  tx_underrun_reg;
    logic                  tx_empty;
    logic                  tx_push;
    logic                  tx_pop;

    assign tx_empty = (tx_count_reg == '0);
    assign tx_ready = (tx_count_reg != FULL_COUNT);
    assign tx_push  = tx_valid & tx_ready;

    always_ff @(posedge m_clock) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_reg] <= tx_data;
        end
    end

    // ---------------- Send path FSM ----------------
    send_state_t state_reg;
    send_state_t state_next;
    logic        pending_reg;
    logic        pending_next;
    logic [7:0]  send_data_reg;
    logic [7:0]  send_data_next;
    logic        serve;
    logic        underrun_set;

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        send_data_next = send_data_reg;
        serve          = 1'b0;
        underrun_set   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (send_ready | pending_reg) begin
                    serve        = 1'b1;
                    pending_next = 1'b0;
                    state_next   = ST_ISSUE;
                    // Decision uses registered occupancy: a byte pushed this cycle is not bypassed.
                    if (!tx_empty) begin
                        send_data_next = tx_mem[tx_rd_ptr_reg];
                    end else begin
                        send_data_next = IDLE_BYTE;
                        underrun_set   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_IDLE;
                if (send_ready) begin
                    pending_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign tx_pop = serve & ~tx_empty;

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_reg       <= ST_IDLE;
            pending_reg     <= 1'b0;
            send_data_reg   <= IDLE_BYTE;
            tx_wr_ptr_reg   <= '0;
            tx_rd_ptr_reg   <= '0;
            tx_count_reg    <= '0;
            tx_underrun_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            send_data_reg <= send_data_next;
            if (tx_push) begin
                tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count_reg <= tx_count_reg + COUNT_ONE;
                2'b01:   tx_count_reg <= tx_count_reg - COUNT_ONE;
                default: tx_count_reg <= tx_count_reg;
            endcase
            if (underrun_set) begin
                tx_underrun_reg <= 1'b1;
            end else if (clr_flags) begin
                tx_underrun_reg <= 1'b0;
            end
        end
    end

    assign send        = (state_reg == ST_ISSUE);
    assign send_data   = send_data_reg;
    assign rx_count    = rx_count_reg;
    assign tx_count    = tx_count_reg;
    assign rx_overflow = rx_overflow_reg;
    assign tx_underrun = tx_underrun_reg;

endmodule
